// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the four-digit hex display scanner.
package hex_scan_pkg;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned DIG_W  = $clog2(DIGITS);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   // Active-low hex font, segment order {g,f,e,d,c,b,a}
   localparam logic [6:0] FONT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex7seg_decode.sv
// Nibble to active-low 7-segment pattern; blank forces all segments off.
module hex7seg_decode
   import hex_scan_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg_n_c
);

   always_comb begin
      seg_n_c = FONT[nibble];
      if (blank) seg_n_c = 7'h7F;
   end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan of a 16-bit hex value onto a common-anode 4-digit
// 7-segment display with guard interval, brightness and leading-zero blanking.
module hex_scan_ctrl
   import hex_scan_pkg::*;
#(
   parameter int unsigned SLOT_CYCLES  = 50000,
   parameter int unsigned GUARD_CYCLES = 500
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [15:0]         hex_value,
   input  logic                blank_lz,
   input  logic [3:0]          bright,
   output logic [6:0]          seg_n,
   output logic [DIGITS-1:0]   an_n,
   output logic                frame_done
);

   localparam int unsigned CNT_W  = $clog2(SLOT_CYCLES);
   localparam int unsigned ON_MAX = SLOT_CYCLES - GUARD_CYCLES;
   localparam int unsigned STEP   = ON_MAX / 16;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [DIG_W-1:0]   dig;
   logic [15:0]        sh_value;
   logic               sh_blank;
   logic [3:0]         sh_bright;

   logic               last_cnt_c;
   logic               frame_end_c;
   logic               load_c;
   logic [CNT_W-1:0]   on_len_c;
   logic               on_c;
   logic [3:0]         nibble_c;
   logic [DIGITS-1:0]  zero_c;
   logic               blank_c;
   logic [6:0]         seg_c;

   assign last_cnt_c  = (cnt == CNT_W'(SLOT_CYCLES - 1));
   assign frame_end_c = (state == SCAN) && enable && last_cnt_c
                        && (dig == DIG_W'(DIGITS - 1));
   assign load_c      = ((state == IDLE) && enable) || frame_end_c;

   // Lit window inside the slot, after the guard interval
   assign on_len_c = (sh_bright == 4'hF) ? CNT_W'(ON_MAX)
                                         : CNT_W'(sh_bright) * CNT_W'(STEP);
   assign on_c     = (state == SCAN) && (cnt >= CNT_W'(GUARD_CYCLES))
                     && ((cnt - CNT_W'(GUARD_CYCLES)) < on_len_c);

   assign nibble_c = sh_value[{dig, 2'b00} +: 4];

   // A digit is a leading zero when it and every more-significant digit are 0
   always_comb begin
      zero_c  = '0;
      blank_c = sh_blank && (dig != '0);
      for (int unsigned i = 0; i < DIGITS; i++) begin
         zero_c[i] = (sh_value[4*i +: 4] == 4'h0);
         if ((DIG_W'(i) >= dig) && !zero_c[i]) blank_c = 1'b0;
      end
   end

   hex7seg_decode u_decode (
      .nibble  (nibble_c),
      .blank   (blank_c),
      .seg_n_c (seg_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         dig        <= '0;
         sh_value   <= '0;
         sh_blank   <= 1'b0;
         sh_bright  <= '0;
         seg_n      <= 7'h7F;
         an_n       <= '1;
         frame_done <= 1'b0;
      end else begin
         seg_n      <= on_c ? seg_c : 7'h7F;
         an_n       <= on_c ? ~(DIGITS'(1) << dig) : '1;
         frame_done <= frame_end_c;

         if (load_c) begin
            sh_value  <= hex_value;
            sh_blank  <= blank_lz;
            sh_bright <= bright;
         end

         case (state)
            IDLE: begin
               cnt <= '0;
               dig <= '0;
               if (enable) state <= SCAN;
            end
            SCAN: begin
               if (!enable) begin
                  state <= IDLE;
                  cnt   <= '0;
                  dig   <= '0;
               end else if (last_cnt_c) begin
                  cnt <= '0;
                  dig <= dig + DIG_W'(1);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               dig   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl: frame-position model plus directed checks.
module tb_hex_scan_ctrl;

   localparam int SLOT  = 40;
   localparam int GUARD = 4;
   localparam int FRAME = 4 * SLOT;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] hex_value = 16'h0;
   logic        blank_lz = 1'b0;
   logic [3:0]  bright = 4'h0;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic        frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   hex_scan_ctrl #(.SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .hex_value  (hex_value),
      .blank_lz   (blank_lz),
      .bright     (bright),
      .seg_n      (seg_n),
      .an_n       (an_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: position within the frame -------------
   logic [6:0] font_m [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   bit          running = 1'b0;
   int          pos = 0;
   logic [15:0] m_val = 16'h0;
   logic        m_blank = 1'b0;
   logic [3:0]  m_bright = 4'h0;
   logic [6:0]  exp_seg = 7'h7F;
   logic [3:0]  exp_an = 4'hF;
   logic        exp_fd = 1'b0;

   function automatic logic [6:0] model_seg(input int slot);
      int upper;
      upper = int'(m_val) >> (4 * slot);
      if (m_blank && slot > 0 && upper == 0) return 7'h7F;
      return font_m[upper & 15];
   endfunction

   always @(posedge clk or posedge reset) begin
      int  slot, c, onlen;
      bit  on;
      if (reset) begin
         running = 1'b0; pos = 0;
         m_val = 16'h0; m_blank = 1'b0; m_bright = 4'h0;
         exp_seg = 7'h7F; exp_an = 4'hF; exp_fd = 1'b0;
      end else begin
         slot  = pos / SLOT;
         c     = pos % SLOT;
         onlen = (m_bright == 4'd15) ? (SLOT - GUARD) : int'(m_bright) * 2;
         on    = running && c >= GUARD && (c - GUARD) < onlen;
         for (int d = 0; d < 4; d++) exp_an[d] = !(on && d == slot);
         exp_seg = on ? model_seg(slot) : 7'h7F;
         exp_fd  = running && enable && pos == FRAME - 1;
         if (!running) begin
            if (enable) begin
               running = 1'b1; pos = 0;
               m_val = hex_value; m_blank = blank_lz; m_bright = bright;
            end
         end else if (!enable) begin
            running = 1'b0; pos = 0;
         end else if (pos == FRAME - 1) begin
            pos = 0;
            m_val = hex_value; m_blank = blank_lz; m_bright = bright;
         end else begin
            pos++;
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_seg_n", 32'(seg_n), 32'(exp_seg));
      chk("cyc_an_n", 32'(an_n), 32'(exp_an));
      chk("cyc_frame_done", 32'(frame_done), 32'(exp_fd));
   end

   // ---------------- observation helpers ---------------------------------------
   int         on_cnt [4];
   logic [6:0] seg_seen [4];
   int         fd_cnt, fd_idx;

   task automatic clear_obs();
      for (int d = 0; d < 4; d++) begin on_cnt[d] = 0; seg_seen[d] = 7'h7F; end
      fd_cnt = 0; fd_idx = -1;
   endtask

   task automatic sample(input int i);
      for (int d = 0; d < 4; d++)
         if (an_n == ~(4'b0001 << d)) begin on_cnt[d]++; seg_seen[d] = seg_n; end
      if (frame_done) begin fd_cnt++; fd_idx = i; end
   endtask

   task automatic observe(input int n);
      clear_obs();
      for (int i = 0; i < n; i++) begin @(negedge clk); sample(i); end
   endtask

   task automatic observe_until_fd();
      int k;
      clear_obs();
      for (k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk); sample(k);
         if (frame_done) break;
      end
      chk("fd_seen_bound", 32'(k < 2 * FRAME), 32'd1);
   endtask

   task automatic wait_fd();
      int k;
      for (k = 0; k < 2 * FRAME + 10; k++) begin
         @(negedge clk);
         if (frame_done) break;
      end
      chk("fd_wait_bound", 32'(k < 2 * FRAME + 10), 32'd1);
   endtask

   // enable already high; first active edge follows this negedge
   task automatic start_check(input logic [6:0] seg0);
      repeat (5) @(negedge clk);
      chk("start_guard_an", 32'(an_n), 32'hF);
      @(negedge clk);
      chk("start_dig0_an", 32'(an_n), 32'hE);
      chk("start_dig0_seg", 32'(seg_n), 32'(seg0));
   endtask

   task automatic check_frame(input string tag, input int on_exp,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
      observe(FRAME);
      for (int d = 0; d < 4; d++) chk({tag, "_on"}, 32'(on_cnt[d]), 32'(on_exp));
      chk({tag, "_seg0"}, 32'(seg_seen[0]), 32'(s0));
      chk({tag, "_seg1"}, 32'(seg_seen[1]), 32'(s1));
      chk({tag, "_seg2"}, 32'(seg_seen[2]), 32'(s2));
      chk({tag, "_seg3"}, 32'(seg_seen[3]), 32'(s3));
      chk({tag, "_fd_cnt"}, 32'(fd_cnt), 32'd1);
      chk({tag, "_fd_idx"}, 32'(fd_idx), 32'(FRAME - 1));
   endtask

   // ---------------- directed scenarios ----------------------------------------
   initial begin
      int fd_quiet, dark;
      #1 reset = 1'b1;
      enable = 1'b1; hex_value = 16'h1234; bright = 4'd15; blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_seg_n", 32'(seg_n), 32'h7F);
      chk("rst_an_n", 32'(an_n), 32'hF);
      chk("rst_fd", 32'(frame_done), 32'h0);
      reset = 1'b0;
      start_check(7'h19);
      wait_fd();
      check_frame("full", 36, 7'h19, 7'h30, 7'h24, 7'h79);

      bright = 4'd4;
      wait_fd();
      check_frame("bright4", 8, 7'h19, 7'h30, 7'h24, 7'h79);
      bright = 4'd0;
      wait_fd();
      check_frame("bright0", 0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

      bright = 4'd15; hex_value = 16'h00A0; blank_lz = 1'b1;
      wait_fd();
      check_frame("blank", 36, 7'h40, 7'h08, 7'h7F, 7'h7F);
      blank_lz = 1'b0;
      wait_fd();
      check_frame("noblank", 36, 7'h40, 7'h08, 7'h40, 7'h40);

      hex_value = 16'h1111;
      wait_fd();
      check_frame("pre_latch", 36, 7'h79, 7'h79, 7'h79, 7'h79);
      repeat (50) @(negedge clk);
      hex_value = 16'h2222;
      observe_until_fd();
      chk("latch_dig2_old", 32'(seg_seen[2]), 32'h79);
      chk("latch_dig3_old", 32'(seg_seen[3]), 32'h79);
      check_frame("post_latch", 36, 7'h24, 7'h24, 7'h24, 7'h24);

      repeat (90) @(negedge clk);
      chk("dis_pre_an", 32'(an_n), 32'hB);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      chk("dis_dark_an", 32'(an_n), 32'hF);
      chk("dis_dark_seg", 32'(seg_n), 32'h7F);
      fd_quiet = 0; dark = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (frame_done) fd_quiet++;
         if (an_n == 4'hF && seg_n == 7'h7F) dark++;
      end
      chk("dis_no_fd", 32'(fd_quiet), 32'd0);
      chk("dis_dark_cycles", 32'(dark), 32'd200);
      hex_value = 16'h5678;
      enable = 1'b1;
      start_check(7'h00);

      #2 reset = 1'b1;
      #1;
      chk("async_seg_n", 32'(seg_n), 32'h7F);
      chk("async_an_n", 32'(an_n), 32'hF);
      chk("async_fd", 32'(frame_done), 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      start_check(7'h00);
      wait_fd();
      check_frame("resume", 36, 7'h00, 7'h78, 7'h02, 7'h12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Scan controller for the four-digit hex display fed by the 16-bit hex-digits PIO value. It takes the PIO's 16-bit output and time-multiplexes it onto a common-anode 7-segment display, one digit per slot, with active-low anode and segment outputs. Each slot has an anti-ghost guard interval and a 16-step brightness control. New values are latched only at frame boundaries, so a digit never changes mid-frame.

## Interface
- SLOT_CYCLES, 50000: clock cycles per digit slot; must be ≥ GUARD_CYCLES+16.
- GUARD_CYCLES, 500: cycles at the start of each slot with all anodes off.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable; 0 forces the display dark.
- hex_value  in  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- blank_lz  in  1  1 enables leading-zero blanking.
- bright  in  4  on-time level; 0 = dark, 15 = full slot.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low; seg_n[0] = a.
- an_n  out  4  digit anodes, active-low; an_n[i] drives digit i.
- frame_done  out  1  one-cycle pulse at each frame boundary (shadow latch point).

## Operation
- Shadow registers hold the values used for display: sh_value, sh_blank, sh_bright.
- Shadow load occurs in two cases only:
  - on the cycle that leaves IDLE;
  - on the last cycle of digit 3's slot.
- Inputs changed at any other time have no effect until the next load.
- State machine:
  - IDLE: outputs dark, cnt=0, dig=0. Go to SCAN when enable=1, loading the shadows.
  - SCAN: cnt counts 0..SLOT_CYCLES-1. At SLOT_CYCLES-1, cnt wraps to 0 and dig increments modulo 4. dig wrapping from 3 to 0 loads the shadows and pulses frame_done.
  - enable=0 in SCAN: go to IDLE on the next edge. cnt and dig are cleared and no frame_done is issued.
- Phase within a slot, with STEP = (SLOT_CYCLES-GUARD_CYCLES)/16 as an elaboration constant:
  - cnt < GUARD_CYCLES: guard, all anodes off.
  - on_len = SLOT_CYCLES-GUARD_CYCLES when sh_bright=15; otherwise on_len = sh_bright*STEP.
  - cnt-GUARD_CYCLES < on_len: on; anode dig is low and seg_n shows the digit.
  - any other cnt: off, all anodes high.
- Segment encoding is the standard hex font, active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- Leading-zero blanking applies when sh_blank=1:
  - digit 3 is blanked if it is 0;
  - digit 2 is blanked if digits 3 and 2 are 0;
  - digit 1 is blanked if digits 3..1 are 0;
  - digit 0 is never blanked.
- A blanked digit drives seg_n=7'h7F, and its anode still follows the phase rules.
- Whenever all anodes are off, seg_n is 7'h7F.

## Timing
- Reset values: state=IDLE, cnt=0, dig=0, all shadows 0, seg_n=7'h7F, an_n=4'hF, frame_done=0.
- seg_n, an_n and frame_done are registered. They reflect the (state, cnt, dig) of the previous cycle, i.e. one cycle of latency.
- Leaving IDLE: the first SCAN cycle has cnt=0, dig=0. an_n for digit 0 first goes low GUARD_CYCLES+1 cycles after enable is sampled high (when sh_bright≠0).
- Frame period is 4*SLOT_CYCLES cycles. frame_done rises one cycle after the last cycle of digit 3's slot.
- enable falling: outputs are dark one cycle after the IDLE transition, i.e. two edges after enable is sampled low.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). Scanning resumes from digit 0 after reset deasserts, provided enable=1.
- Simultaneous enable=1 and reset=1: reset wins.

## Structure
- Shared package hex_scan_pkg holds:
  - the state enum (IDLE, SCAN);
  - the 16-entry font constant array;
  - localparam DIGITS=4.
- One sub-module, hex7seg_decode: combinational 4-bit nibble plus blank input to 7-bit seg_n, using the package font.
- Counters and shadow registers live in hex_scan_ctrl.

## Test plan
All scenarios use SLOT_CYCLES=40, GUARD_CYCLES=4, so STEP=2.
- Reset and enable: hold reset, then release with enable=1, hex_value=16'h1234, bright=15 -> seg_n=7'h7F, an_n=4'hF in reset. Digit 0 anode goes low 5 cycles after enable, showing 7'h19, and stays on for 36 cycles. Digits 1, 2, 3 show 7'h30, 7'h24, 7'h79. frame_done pulses every 160 cycles.
- Brightness: bright=4 -> each anode is low for exactly 8 cycles per 40-cycle slot. bright=0 -> an_n stays 4'hF.
- Leading-zero blanking: hex_value=16'h00A0, blank_lz=1 ->
  - digits 3 and 2 show 7'h7F;
  - digit 1 shows 7'h08;
  - digit 0 shows 7'h40.
  - With blank_lz=0, digit 3 shows 7'h40.
- Frame-coherent latch: change hex_value from 16'h1111 to 16'h2222 during digit 1's slot -> digits 2 and 3 of that frame still show 7'h79. After the frame_done pulse, all digits show 7'h24.
- Disable and reset mid-frame:
  - Drop enable during digit 2 -> an_n=4'hF within 2 edges, with no frame_done. Re-enable -> scanning restarts at digit 0 with the shadows reloaded.
  - Assert reset mid-slot -> outputs return to reset values at once, without waiting for a clock edge.
